// File: rtl/arb_pkg.sv
// Shared types and width helper for the channel arbiter and its priority encoder.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Bit width needed to hold an index into n items; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rotating_priority_enc.sv
// Combinational rotating priority encoder: the first set request at or after base
// (wrapping past N_CH-1 to 0) wins.
module rotating_priority_enc
    import arb_pkg::*;
#(
    parameter int N_CH = 16,
    parameter int IW   = idx_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   base,
    output logic [IW-1:0]   winner,
    output logic            found
);

    logic [IW-1:0]   cand [N_CH];
    logic [N_CH-1:0] hit;

    // Offset gi from base maps to a channel index; the wrap is an explicit compare
    // so non-power-of-two channel counts wrap at N_CH-1 rather than at 2**IW-1.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum      = {1'b0, base} + (IW+1)'(gi);
        assign cand[gi] = (sum > (IW+1)'(N_CH - 1)) ? IW'(sum - (IW+1)'(N_CH))
                                                     : sum[IW-1:0];
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner = cand[i];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_arbiter.sv
// Registered N_CH-channel arbiter with fixed-priority / round-robin modes, a latched
// minimum hold time and a break-before-make guard interval between grants.
module channel_arbiter
    import arb_pkg::*;
#(
    parameter int N_CH      = 16,
    parameter int HOLD_W    = 8,
    parameter int GUARD_CYC = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       mode_i,
    input  logic [N_CH-1:0]            req_i,
    input  logic                       done_i,
    input  logic [HOLD_W-1:0]          hold_cycles_i,
    output logic [N_CH-1:0]            grant_o,
    output logic [idx_width(N_CH)-1:0] grant_idx_o,
    output logic                       valid_o,
    output logic                       busy_o
);

    localparam int IW = idx_width(N_CH);
    localparam int GW = idx_width(GUARD_CYC);

    arb_state_t        state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_lim_q, hold_lim_d;
    logic [GW-1:0]     guard_cnt_q, guard_cnt_d;

    arb_mode_t     mode;
    logic [IW-1:0] base;
    logic [IW-1:0] winner;
    logic          found;
    logic          release_ok;
    logic          guard_last;

    assign mode = arb_mode_t'(mode_i);
    assign base = (mode == ARB_RR) ? rr_ptr_q : '0;

    rotating_priority_enc #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_enc (
        .req    (req_i),
        .base   (base),
        .winner (winner),
        .found  (found)
    );

    assign release_ok = (hold_cnt_q >= hold_lim_q) && (done_i || !req_i[idx_q]);
    assign guard_last = (guard_cnt_q == GW'(GUARD_CYC - 1));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        hold_lim_d  = hold_lim_q;
        guard_cnt_d = guard_cnt_q;

        if (!enable_i) begin
            // Abort: straight to IDLE with no guard; the round-robin pointer survives.
            state_d     = IDLE;
            grant_d     = '0;
            idx_d       = '0;
            hold_cnt_d  = '0;
            guard_cnt_d = '0;
        end else begin
            case (state_q)
                GRANT: begin
                    if (release_ok) begin
                        state_d     = GUARD;
                        grant_d     = '0;
                        guard_cnt_d = '0;
                    end else if (hold_cnt_q != hold_lim_q) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                GUARD: begin
                    if (!guard_last) begin
                        guard_cnt_d = guard_cnt_q + GW'(1);
                    end else if (!found) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
                default: ;
            endcase

            // A new grant is issued from IDLE, or directly from the last GUARD cycle.
            if (found && ((state_q == IDLE) || ((state_q == GUARD) && guard_last))) begin
                state_d         = GRANT;
                grant_d         = '0;
                grant_d[winner] = 1'b1;
                idx_d           = winner;
                hold_cnt_d      = '0;
                hold_lim_d      = hold_cycles_i;
                rr_ptr_d        = (winner == IW'(N_CH - 1)) ? '0 : winner + IW'(1);
            end
        end

        valid_d = |grant_d;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            hold_lim_q  <= '0;
            guard_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_lim_q  <= hold_lim_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed bench for channel_arbiter: a 16-channel and a 12-channel instance share
// the clock and reset; each step advances one clock and checks registered outputs.
module tb_channel_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-channel instance
    logic        en, mode, done;
    logic [15:0] req;
    logic [7:0]  hold;
    logic [15:0] grant;
    logic [3:0]  idx;
    logic        valid, busy;

    // 12-channel instance
    logic        en12, mode12, done12;
    logic [11:0] req12;
    logic [7:0]  hold12;
    logic [11:0] grant12;
    logic [3:0]  idx12;
    logic        valid12, busy12;

    int checks = 0;
    int passed = 0;

    channel_arbiter #(.N_CH(16), .HOLD_W(8), .GUARD_CYC(1)) dut16 (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (en),
        .mode_i        (mode),
        .req_i         (req),
        .done_i        (done),
        .hold_cycles_i (hold),
        .grant_o       (grant),
        .grant_idx_o   (idx),
        .valid_o       (valid),
        .busy_o        (busy)
    );

    channel_arbiter #(.N_CH(12), .HOLD_W(8), .GUARD_CYC(1)) dut12 (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (en12),
        .mode_i        (mode12),
        .req_i         (req12),
        .done_i        (done12),
        .hold_cycles_i (hold12),
        .grant_o       (grant12),
        .grant_idx_o   (idx12),
        .valid_o       (valid12),
        .busy_o        (busy12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        $display("check %-18s observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] g, input logic [3:0] i,
                         input logic b);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".idx"},   32'(idx),   32'(i));
        chk({tag, ".valid"}, 32'(valid), 32'(g != 16'h0));
        chk({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    initial begin
        en = 0; mode = 0; done = 0; req = '0; hold = '0;
        en12 = 0; mode12 = 0; done12 = 0; req12 = '0; hold12 = '0;

        // Reset state
        rst = 1; tick();
        chk16("reset", 16'h0000, 4'd0, 1'b0);
        chk("reset12.grant", 32'(grant12), 32'h0);
        chk("reset12.busy",  32'(busy12),  32'h0);
        rst = 0;

        // 1: fixed priority, ch1 always beats ch4
        en = 1; mode = 0; hold = 0; req = 16'h0012; done = 0;
        tick(); chk16("t1.grant", 16'h0002, 4'd1, 1'b1);
        tick(); chk16("t1.hold", 16'h0002, 4'd1, 1'b1);
        done = 1;
        tick(); chk("t1.guard.grant", 32'(grant), 32'h0);
        chk("t1.guard.busy", 32'(busy), 32'h1);
        done = 0;
        tick(); chk16("t1.regrant", 16'h0002, 4'd1, 1'b1);
        en = 0;
        tick(); chk16("t1.abort", 16'h0000, 4'd0, 1'b0);

        // 2: round-robin alternation from a fresh pointer
        rst = 1; tick(); rst = 0;
        en = 1; mode = 1; hold = 0; req = 16'h0012; done = 1;
        tick(); chk("t2.g0", 32'(grant), 32'h0002);
        tick(); chk("t2.g1", 32'(grant), 32'h0000);
        tick(); chk("t2.g2", 32'(grant), 32'h0010);
        chk("t2.idx2", 32'(idx), 32'd4);
        tick(); chk("t2.g3", 32'(grant), 32'h0000);
        tick(); chk("t2.g4", 32'(grant), 32'h0002);
        en = 0; done = 0; req = '0;
        tick();

        // 3: 12-channel round-robin wraps 11 -> 0
        en12 = 1; mode12 = 1; hold12 = 0; req12 = 12'h801; done12 = 1;
        tick(); chk("t3.g0", 32'(grant12), 32'h001);
        chk("t3.idx0", 32'(idx12), 32'd0);
        tick(); chk("t3.g1", 32'(grant12), 32'h000);
        tick(); chk("t3.g2", 32'(grant12), 32'h800);
        chk("t3.idx2", 32'(idx12), 32'd11);
        tick(); chk("t3.g3", 32'(grant12), 32'h000);
        tick(); chk("t3.g4", 32'(grant12), 32'h001);
        chk("t3.idx4", 32'(idx12), 32'd0);
        en12 = 0;

        // 4: H=3 holds four cycles despite done; then H=0 holds one
        en = 1; mode = 0; hold = 8'd3; req = 16'h0020; done = 1;
        tick(); chk("t4.h1", 32'(grant), 32'h0020);
        tick(); chk("t4.h2", 32'(grant), 32'h0020);
        tick(); chk("t4.h3", 32'(grant), 32'h0020);
        tick(); chk("t4.h4", 32'(grant), 32'h0020);
        hold = 8'd0;
        tick(); chk("t4.rel", 32'(grant), 32'h0000);
        chk("t4.rel.busy", 32'(busy), 32'h1);
        tick(); chk("t4.h0.g", 32'(grant), 32'h0020);
        tick(); chk("t4.h0.rel", 32'(grant), 32'h0000);
        req = '0;
        tick(); chk16("t4.idle", 16'h0000, 4'd0, 1'b0);

        // 5: abort mid-grant keeps rr_ptr=6, so ch15 beats ch0 afterwards
        mode = 1; done = 0; req = 16'h0020;
        tick(); chk16("t5.g5", 16'h0020, 4'd5, 1'b1);
        tick(); chk("t5.held", 32'(grant), 32'h0020);
        en = 0;
        tick(); chk16("t5.abort", 16'h0000, 4'd0, 1'b0);
        en = 1; req = 16'h8001;
        tick(); chk16("t5.g15", 16'h8000, 4'd15, 1'b1);
        en = 0;
        tick();

        // 6: reset mid-grant on ch7 clears outputs and rr_ptr
        en = 1; mode = 1; req = 16'h0080;
        tick(); chk16("t6.g7", 16'h0080, 4'd7, 1'b1);
        rst = 1;
        tick(); chk16("t6.reset", 16'h0000, 4'd0, 1'b0);
        rst = 0; req = 16'h8001;
        tick(); chk16("t6.g0", 16'h0001, 4'd0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
